// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle RV32M multiply/divide unit.
// Radix-2 shift-add / restoring divide with a fast path for corner cases.
module mdu_iterative #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             zero_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int DW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic             neg_q;
    logic [DW-1:0]    acc_q;
    logic [WIDTH-1:0] opnd_q;
    logic             pend_q;
    logic [WIDTH-1:0] pend_res_q;

    logic             accept;
    logic             a_sgn;
    logic             b_sgn;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_in;
    logic             div_zero;
    logic             ovf;
    logic [DW-1:0]    fast_prod;
    logic             fast_hit;
    logic [WIDTH-1:0] fast_res;

    logic [WIDTH:0]   mul_sum;
    logic [DW-1:0]    mul_next;
    logic [WIDTH:0]   div_part;
    logic [WIDTH:0]   div_trial;
    logic [DW-1:0]    div_next;
    logic [DW-1:0]    iter_next;
    logic [WIDTH-1:0] div_val;
    logic [WIDTH-1:0] fix_res;

    // Signed product correction and low/high half select.
    function automatic logic [WIDTH-1:0] mul_sel(
        input logic          lo,
        input logic          neg,
        input logic [DW-1:0] p
    );
        logic [DW-1:0] s;
        s = neg ? -p : p;
        return lo ? s[WIDTH-1:0] : s[DW-1:WIDTH];
    endfunction

    assign ready_o = (state_q == S_IDLE);
    assign busy_o  = ~ready_o;
    assign zero_o  = (result_o == '0);
    assign accept  = valid_i & ready_o & ~flush_i;

    // Operand signedness: divides signed for DIV/REM, multiplies per RV32M.
    assign a_sgn = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    assign b_sgn = op_i[2] ? ~op_i[0] : ~op_i[1];
    assign sa    = a_sgn & src_a_i[WIDTH-1];
    assign sb    = b_sgn & src_b_i[WIDTH-1];
    assign mag_a = sa ? -src_a_i : src_a_i;
    assign mag_b = sb ? -src_b_i : src_b_i;

    // Remainder follows the dividend; everything else follows sa^sb.
    assign neg_in = (op_i[2] & op_i[1]) ? sa : (sa ^ sb);

    assign div_zero = (src_b_i == '0);
    assign ovf      = op_i[2] & ~op_i[0]
                    & (src_a_i == MIN_NEG)
                    & (src_b_i == ALL_ONES);

    assign fast_prod = DW'(mag_a) * DW'(mag_b);

    // Fast-path detection and its result value.
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        if (op_i[2]) begin
            if (div_zero) begin
                fast_hit = 1'b1;
                fast_res = op_i[1] ? src_a_i : ALL_ONES;
            end else if (ovf) begin
                fast_hit = 1'b1;
                fast_res = op_i[1] ? '0 : MIN_NEG;
            end
        end else if (FAST_MUL) begin
            fast_hit = 1'b1;
            fast_res = mul_sel(op_i[1:0] == 2'b00, neg_in, fast_prod);
        end
    end

    // One radix-2 step: acc holds {high, low} of product or {rem, quo}.
    assign mul_sum  = {1'b0, acc_q[DW-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    assign div_part  = acc_q[DW-1:WIDTH-1];
    assign div_trial = div_part - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH]
                     ? {acc_q[DW-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign iter_next = op_q[2] ? div_next : mul_next;

    // Sign correction and result select for the FIX state.
    always_comb begin
        div_val = op_q[1] ? acc_q[DW-1:WIDTH] : acc_q[WIDTH-1:0];
        fix_res = '0;
        if (op_q[2]) begin
            fix_res = neg_q ? -div_val : div_val;
        end else begin
            fix_res = mul_sel(op_q[1:0] == 2'b00, neg_q, acc_q);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (valid_i && !fast_hit) state_d = S_CALC;
                S_CALC: if (cnt_q == LAST) state_d = S_FIX;
                S_FIX:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Operand latch on accept and iterative datapath stepping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (accept && !fast_hit) begin
            cnt_q  <= '0;
            op_q   <= op_i;
            neg_q  <= neg_in;
            acc_q  <= {{WIDTH{1'b0}}, (op_i[2] ? mag_a : mag_b)};
            opnd_q <= op_i[2] ? mag_b : mag_a;
        end else if (state_q == S_CALC && !flush_i) begin
            acc_q <= iter_next;
            if (cnt_q != LAST) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Result register, completion pulse and pending fast-path result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result_o   <= '0;
            valid_o    <= 1'b0;
            pend_q     <= 1'b0;
            pend_res_q <= '0;
        end else begin
            valid_o <= 1'b0;
            pend_q  <= 1'b0;
            if (!flush_i) begin
                if (pend_q) begin
                    result_o <= pend_res_q;
                    valid_o  <= 1'b1;
                end
                if (state_q == S_FIX) begin
                    result_o <= fix_res;
                    valid_o  <= 1'b1;
                end
                if (accept && fast_hit) begin
                    pend_q     <= 1'b1;
                    pend_res_q <= fast_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed checks of mdu_iterative.
// Covers WIDTH=32 iterative and WIDTH=8 with FAST_MUL.
module tb_mdu_iterative;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        v32, fl32, rdy32, vo32, bz32, z32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;

    logic        v8, fl8, rdy8, vo8, bz8, z8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, res8;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_iterative #(.WIDTH(32), .FAST_MUL(1'b0)) u_dut32 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .valid_i  (v32),
        .ready_o  (rdy32),
        .op_i     (op32),
        .src_a_i  (a32),
        .src_b_i  (b32),
        .flush_i  (fl32),
        .result_o (res32),
        .valid_o  (vo32),
        .busy_o   (bz32),
        .zero_o   (z32)
    );

    mdu_iterative #(.WIDTH(8), .FAST_MUL(1'b1)) u_dut8 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .valid_i  (v8),
        .ready_o  (rdy8),
        .op_i     (op8),
        .src_a_i  (a8),
        .src_b_i  (b8),
        .flush_i  (fl8),
        .result_o (res8),
        .valid_o  (vo8),
        .busy_o   (bz8),
        .zero_o   (z8)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic go32(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        @(negedge clk);
        v32  = 1'b1;
        op32 = op;
        a32  = a;
        b32  = b;
    endtask

    // Accept edge, then count edges until valid_o (bounded).
    task automatic wait32(output int lat, output logic rdy_acc);
        @(posedge clk);
        #1;
        v32  = 1'b0;
        a32  = $urandom;
        b32  = $urandom;
        op32 = 3'($urandom);
        rdy_acc = rdy32;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (vo32) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run32(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic rdy;
        go32(op, a, b);
        wait32(lat, rdy);
        chk({tag, "/res"}, 64'(res32), 64'(exp));
        chk({tag, "/lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/zero"}, 64'(z32), 64'(exp == 32'h0));
        chk({tag, "/rdy"}, 64'(rdy), 64'(exp_lat == 1));
    endtask

    task automatic run8(input string tag, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        v8  = 1'b1;
        op8 = op;
        a8  = a;
        b8  = b;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (vo8) begin
                lat = i;
                break;
            end
        end
        chk({tag, "/res"}, 64'(res8), 64'(exp));
        chk({tag, "/lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic count_valid32(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (vo32) n++;
        end
    endtask

    initial begin
        int   lat;
        int   nv;
        logic rdy;

        v32 = 1'b0; fl32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        v8  = 1'b0; fl8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;

        #1;
        chk("rst/res", 64'(res32), 64'h0);
        chk("rst/zero", 64'(z32), 64'h1);
        chk("rst/rdy", 64'(rdy32), 64'h1);
        chk("rst/busy", 64'(bz32), 64'h0);
        chk("rst/valid", 64'(vo32), 64'h0);
        #20;
        rst_n = 1'b1;

        run32("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run32("mulh", MULH, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 33);
        run32("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 33);
        run32("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 33);

        run32("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run32("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run32("remu", REMU, 32'd14, 32'd7, 32'd0, 33);

        run32("div0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run32("remu0", REMU, 32'd5, 32'd0, 32'd5, 1);
        run32("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 1);
        run32("removf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        run32("divu", DIVU, 32'd100, 32'd7, 32'd14, 33);
        v32  = 1'b1;
        op32 = DIVU;
        a32  = 32'd1000;
        b32  = 32'd3;
        wait32(lat, rdy);
        chk("b2b/res", 64'(res32), 64'd333);
        chk("b2b/lat", 64'(lat), 64'd33);

        go32(DIVU, 32'd50000, 32'd7);
        @(posedge clk);
        #1;
        v32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        fl32 = 1'b1;
        @(posedge clk);
        #1;
        fl32 = 1'b0;
        chk("flush/rdy", 64'(rdy32), 64'h1);
        chk("flush/valid", 64'(vo32), 64'h0);
        count_valid32(40, nv);
        chk("flush/nvalid", 64'(nv), 64'h0);
        chk("flush/res", 64'(res32), 64'd333);

        @(negedge clk);
        v32  = 1'b1;
        fl32 = 1'b1;
        op32 = DIVU;
        a32  = 32'd9;
        b32  = 32'd3;
        @(posedge clk);
        #1;
        chk("flacc/rdy", 64'(rdy32), 64'h1);
        v32  = 1'b0;
        fl32 = 1'b0;
        count_valid32(40, nv);
        chk("flacc/nvalid", 64'(nv), 64'h0);

        go32(MUL, 32'd5, 32'd6);
        @(posedge clk);
        #1;
        v32 = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst/res", 64'(res32), 64'h0);
        chk("midrst/zero", 64'(z32), 64'h1);
        chk("midrst/rdy", 64'(rdy32), 64'h1);
        chk("midrst/valid", 64'(vo32), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run32("mul34", MUL, 32'd3, 32'd4, 32'd12, 33);

        run8("w8mul", MUL, 8'h0F, 8'h0F, 8'hE1, 1);
        run8("w8mulh", MULH, 8'h80, 8'h80, 8'h40, 1);
        run8("w8div", DIV, 8'h80, 8'hFF, 8'h80, 1);
        run8("w8divu", DIVU, 8'hFF, 8'h10, 8'h0F, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
